key_assembler: RTL



---
 rtl/key_pkg.sv | 23 ++
 rtl/timeout_counter.sv | 27 ++
 rtl/key_assembler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key assembler.
// Holds the FSM state enum, data widths, defaults and a counter-width helper.
package key_pkg;

   localparam int KEY_W  = 32;
   localparam int BYTE_W = 8;

   localparam int unsigned TIMEOUT_DEF        = 1024;
   localparam int unsigned MAX_TRIES_DEF      = 8;
   localparam int unsigned LOCKOUT_CYCLES_DEF = 65536;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      LOCKED
   } state_t;

   // Bits needed to hold 0..n, never less than one.
   function automatic int unsigned cw(input int unsigned n);
      return (n == 0) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/timeout_counter.sv
// Loadable down-counter, flags expired while the count sits at zero.
// Ports: clk, rst (sync), load/load_val, en (decrement), expired.
module timeout_counter #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/key_assembler.sv
// Packs four handshaked bytes into a 32-bit key with timeout and lockout.
// Ports: clk, rst, in_data/in_valid/in_ready, key, key_strobe, abort, locked, byte_count.
module key_assembler
   import key_pkg::*;
#(
   parameter bit          MSB_FIRST      = 1'b1,
   parameter int unsigned TIMEOUT        = TIMEOUT_DEF,
   parameter int unsigned MAX_TRIES      = MAX_TRIES_DEF,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [KEY_W-1:0]  key,
   output logic              key_strobe,
   output logic              abort,
   output logic              locked,
   output logic [1:0]        byte_count
);

   localparam int unsigned IW = cw(TIMEOUT);
   localparam int unsigned LW = cw(LOCKOUT_CYCLES);
   localparam int unsigned AW = cw(MAX_TRIES);

   localparam logic [IW-1:0] IDLE_LOAD = IW'(TIMEOUT);
   // Loaded with one less so expiry lands in the last locked cycle.
   localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
   localparam logic [AW-1:0] TRY_MAX   = AW'(MAX_TRIES);

   state_t state;
   state_t state_nx;

   logic [BYTE_W-1:0] b0;
   logic [BYTE_W-1:0] b1;
   logic [BYTE_W-1:0] b2;
   logic [AW-1:0]     tries;
   logic [AW-1:0]     tries_inc;
   logic [KEY_W-1:0]  word;

   logic accept;
   logic done;
   logic lock_now;
   logic to_fire;
   logic idle_exp;
   logic lock_exp;

   assign accept = in_valid & in_ready;
   assign done   = (state == COLLECT) && accept
                   && (byte_count == 2'd3);

   assign tries_inc = (tries == '1) ? tries : tries + 1'b1;
   assign lock_now  = done && (MAX_TRIES != 0)
                      && (tries_inc == TRY_MAX);

   // A byte arriving in the expiry cycle wins over the timeout.
   assign to_fire = (TIMEOUT != 0) && (state == COLLECT)
                    && idle_exp && !accept;

   assign word = MSB_FIRST ? {b0, b1, b2, in_data}
                           : {in_data, b2, b1, b0};

   assign locked = (state == LOCKED);

   timeout_counter #(.W(IW)) u_idle (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (IDLE_LOAD),
      .en       (state == COLLECT),
      .expired  (idle_exp)
   );

   timeout_counter #(.W(LW)) u_lock (
      .clk      (clk),
      .rst      (rst),
      .load     (lock_now),
      .load_val (LOCK_LOAD),
      .en       (state == LOCKED),
      .expired  (lock_exp)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept)
               state_nx = COLLECT;
         end
         COLLECT: begin
            if (done)
               state_nx = lock_now ? LOCKED : IDLE;
            else if (to_fire)
               state_nx = IDLE;
         end
         LOCKED: begin
            if (lock_exp)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         key        <= '0;
         key_strobe <= 1'b0;
         abort      <= 1'b0;
         byte_count <= 2'd0;
         tries      <= '0;
         b0         <= '0;
         b1         <= '0;
         b2         <= '0;
      end else begin
         state      <= state_nx;
         in_ready   <= (state_nx != LOCKED);
         key_strobe <= done;
         abort      <= to_fire;
         if (done) begin
            key        <= word;
            byte_count <= 2'd0;
            tries      <= tries_inc;
         end else if (accept) begin
            unique case (byte_count)
               2'd0:    b0 <= in_data;
               2'd1:    b1 <= in_data;
               default: b2 <= in_data;
            endcase
            byte_count <= byte_count + 2'd1;
         end else if (to_fire) begin
            byte_count <= 2'd0;
         end
         if (state == LOCKED && lock_exp)
            tries <= '0;
      end
   end

endmodule
